// File: rtl/timer_core_mc.sv
`default_nettype none
// ============================================================================
// timer_core_mc : multi-channel prescaled timer (one-shot / periodic / free-run)
// Optional sticky status + irq: define TIMER_CORE_MC_STATUS_EN.   Rev 1.0
// ============================================================================
module timer_core_mc #(
  parameter int NUM_CH          = 2,
  parameter int WIDTH           = 32,
  parameter int PRESCALER_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH*PRESCALER_WIDTH-1:0] prescaler_init,
  input  logic [NUM_CH*WIDTH-1:0]           timer_init,
  input  logic [NUM_CH*2-1:0]               mode,
  input  logic [NUM_CH-1:0]                 start,
  input  logic [NUM_CH-1:0]                 stop,
  input  logic [NUM_CH-1:0]                 clear,
  output logic [NUM_CH*WIDTH-1:0]           curr_timer,
  output logic [NUM_CH-1:0]                 running,
  output logic [NUM_CH-1:0]                 expired,
  output logic [NUM_CH-1:0]                 status,
  output logic                              irq
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  logic [NUM_CH-1:0] expire_evt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                     state, state_nxt;
    logic [PRESCALER_WIDTH-1:0] psc, psc_nxt, p_cmp;
    logic [WIDTH-1:0]           tmr, tmr_nxt, t_cmp;
    logic                       run_reg, run_nxt, exp_reg, exp_nxt;
    logic [1:0]                 ch_mode;

    assign p_cmp   = prescaler_init[i*PRESCALER_WIDTH +: PRESCALER_WIDTH];
    assign t_cmp   = timer_init[i*WIDTH +: WIDTH];
    assign ch_mode = mode[i*2 +: 2];

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= IDLE;
        psc     <= '0;
        tmr     <= '0;
        run_reg <= 1'b0;
        exp_reg <= 1'b0;
      end else begin
        state   <= state_nxt;
        psc     <= psc_nxt;
        tmr     <= tmr_nxt;
        run_reg <= run_nxt;
        exp_reg <= exp_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      psc_nxt   = psc;
      tmr_nxt   = tmr;
      run_nxt   = run_reg;
      exp_nxt   = 1'b0;
      case (state)
        IDLE: begin
          if (start[i]) begin
            psc_nxt   = '0;
            tmr_nxt   = '0;
            run_nxt   = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          // stop outranks an expiring tick: counters freeze, no pulse
          if (stop[i]) begin
            run_nxt   = 1'b0;
            state_nxt = IDLE;
          end else if (psc != p_cmp) begin
            psc_nxt = psc + PRESCALER_WIDTH'(1);
          end else begin
            psc_nxt = '0;
            if (ch_mode == MODE_ONESHOT && tmr == t_cmp) begin
              run_nxt   = 1'b0;
              exp_nxt   = 1'b1;
              state_nxt = IDLE;
            end else if (ch_mode == MODE_PERIODIC && tmr == t_cmp) begin
              tmr_nxt = '0;
              exp_nxt = 1'b1;
            end else begin
              tmr_nxt = tmr + WIDTH'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign curr_timer[i*WIDTH +: WIDTH] = tmr;
    assign running[i]                   = run_reg;
    assign expired[i]                   = exp_reg;
    assign expire_evt[i]                = exp_nxt;
  end

`ifdef TIMER_CORE_MC_STATUS_EN
  logic [NUM_CH-1:0] status_reg;
  logic              irq_reg;

  // status rises together with expired; a coincident clear loses to the set
  always_ff @(posedge clk) begin
    if (reset) begin
      status_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      status_reg <= expire_evt | (status_reg & ~clear);
      irq_reg    <= |status_reg;
    end
  end

  assign status = status_reg;
  assign irq    = irq_reg;
`else
  logic unused_status_inputs;
  assign unused_status_inputs = ^{clear, expire_evt};
  assign status = '0;
  assign irq    = 1'b0;
`endif

endmodule
`default_nettype wire
